// File: rtl/leaf_gpu_ingress_buffer_if.sv
// Flit stream bundle between GPU, ingress buffer and leaf router.
// The producer drives data/dest/valid and the consumer drives ready.
interface leaf_gpu_ingress_buffer_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 6
);
  logic [DWIDTH-1:0] data;
  logic [AWIDTH-1:0] dest;
  logic              valid;
  logic              ready;

  modport master (output data, output dest, output valid, input ready);
  modport slave  (input data, input dest, input valid, output ready);
endinterface

// File: rtl/leaf_gpu_ingress_buffer.sv
// GPU-to-leaf-router ingress FIFO: array of FIFO_DEPTH-1 entries feeding a registered output stage.
// Optional LEAF_INGRESS_STATS_EN adds push/pop/stall counters.
module leaf_gpu_ingress_buffer #(
  parameter int DWIDTH     = 16,
  parameter int AWIDTH     = 6,
  parameter int FIFO_DEPTH = 8,
  parameter int LWIDTH     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  leaf_gpu_ingress_buffer_if.slave   gpu,
  leaf_gpu_ingress_buffer_if.master  router,
  output logic                       fifo_full,
  output logic                       fifo_empty,
  output logic [LWIDTH-1:0]          level
`ifdef LEAF_INGRESS_STATS_EN
  ,
  output logic [31:0]                push_count,
  output logic [31:0]                pop_count,
  output logic [15:0]                stall_cycles
`endif
);

  localparam int ADEPTH = FIFO_DEPTH - 1;
  localparam int PWIDTH = (ADEPTH > 1) ? $clog2(ADEPTH) : 1;
  localparam logic [LWIDTH-1:0] FULL_LEVEL = LWIDTH'(FIFO_DEPTH);
  localparam logic [PWIDTH-1:0] LAST_PTR   = PWIDTH'(ADEPTH - 1);

  logic [DWIDTH+AWIDTH-1:0] mem [ADEPTH];
  logic [PWIDTH-1:0]        wr_ptr;
  logic [PWIDTH-1:0]        rd_ptr;
  logic [LWIDTH-1:0]        level_q;
  logic [LWIDTH-1:0]        level_next;
  logic [LWIDTH-1:0]        arr_count;
  logic                     in_ready_q;
  logic                     full_q;
  logic                     empty_q;
  logic [DWIDTH-1:0]        out_data_q;
  logic [AWIDTH-1:0]        out_dest_q;
  logic                     out_valid_q;
  logic                     push;
  logic                     pop;
  logic                     arr_has;
  logic                     mem_write;
  logic                     mem_read;

  function automatic logic [PWIDTH-1:0] next_ptr(input logic [PWIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign push      = gpu.valid && in_ready_q;
  assign pop       = out_valid_q && router.ready;
  assign arr_count = level_q - LWIDTH'(out_valid_q);
  assign arr_has   = (arr_count != '0);
  // Array is bypassed when the output stage is empty or drains with nothing queued behind it.
  assign mem_write = push && out_valid_q && !(pop && !arr_has);
  assign mem_read  = pop && arr_has;

  always_comb begin
    level_next = level_q;
    if (push && !pop)
      level_next = level_q + 1'b1;
    else if (pop && !push)
      level_next = level_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (mem_write)
      mem[wr_ptr] <= {gpu.dest, gpu.data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      in_ready_q  <= 1'b1;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      out_data_q  <= '0;
      out_dest_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      level_q    <= level_next;
      in_ready_q <= (level_next != FULL_LEVEL);
      full_q     <= (level_next == FULL_LEVEL);
      empty_q    <= (level_next == '0);
      if (mem_write)
        wr_ptr <= next_ptr(wr_ptr);
      if (mem_read)
        rd_ptr <= next_ptr(rd_ptr);
      if (!out_valid_q || pop) begin
        if (mem_read) begin
          {out_dest_q, out_data_q} <= mem[rd_ptr];
          out_valid_q              <= 1'b1;
        end else if (push) begin
          out_data_q  <= gpu.data;
          out_dest_q  <= gpu.dest;
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

`ifdef LEAF_INGRESS_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      push_count   <= '0;
      pop_count    <= '0;
      stall_cycles <= '0;
    end else begin
      if (push)
        push_count <= push_count + 32'd1;
      if (pop)
        pop_count <= pop_count + 32'd1;
      if (out_valid_q && !router.ready && (stall_cycles != 16'hFFFF))
        stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign gpu.ready    = in_ready_q;
  assign router.data  = out_data_q;
  assign router.dest  = out_dest_q;
  assign router.valid = out_valid_q;
  assign fifo_full    = full_q;
  assign fifo_empty   = empty_q;
  assign level        = level_q;

endmodule
